// File: rtl/debug_hex_pager.sv
// Seven-segment debug pager: picks one of NUM_PAGES hex words, either by hand or by timed rotation,
// with freeze, an event-triggered snapshot of every page and optional leading-zero blanking.
module debug_hex_pager #(
    parameter int NUM_PAGES    = 8,
    parameter int DIGITS       = 6,
    parameter int SEL_W        = $clog2(NUM_PAGES),
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int LZ_BLANK     = 0
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [NUM_PAGES*DIGITS*4-1:0] page_data,
    input  logic [SEL_W-1:0]              page_sel,
    input  logic                          auto_mode,
    input  logic                          freeze,
    input  logic                          capture_stb,
    input  logic                          show_snapshot,
    output logic [DIGITS*4-1:0]           hex_digits,
    output logic [DIGITS-1:0]             digit_on,
    output logic [SEL_W-1:0]              cur_page,
    output logic                          snap_valid
);

    localparam int PW    = DIGITS * 4;
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [SEL_W:0]   NUM_PAGES_L = (SEL_W+1)'(NUM_PAGES);
    localparam logic [SEL_W-1:0] LAST_PAGE   = SEL_W'(NUM_PAGES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0]    FILL_ONES   = {DIGITS{4'h1}};

    logic [NUM_PAGES*PW-1:0] snapshot_reg, snapshot_next;
    logic                    snap_valid_reg, snap_valid_next;
    logic [CNT_W-1:0]        dwell_cnt_reg, dwell_cnt_next;
    logic [SEL_W-1:0]        rot_idx_reg, rot_idx_next;
    logic [SEL_W-1:0]        cur_page_reg, cur_page_next;
    logic                    auto_d_reg;
    logic [PW-1:0]           hex_digits_reg, hex_digits_next;
    logic [DIGITS-1:0]       digit_on_reg, digit_on_next;

    logic [PW-1:0]     live_pages [NUM_PAGES];
    logic [PW-1:0]     snap_pages [NUM_PAGES];
    logic [PW-1:0]     disp_val;
    logic [SEL_W-1:0]  disp_idx;
    logic [DIGITS-1:0] nz, lz_on;
    logic              auto_rise, dwell_wrap, sel_in_range, disp_in_range;

    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_pages
        assign live_pages[gi] = page_data[gi*PW +: PW];
        assign snap_pages[gi] = snapshot_reg[gi*PW +: PW];
    end

    // A digit stays lit while any digit at or above it is non-zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        assign nz[gi] = |disp_val[gi*4 +: 4];
        if (gi == 0) begin : g_lsd
            assign lz_on[gi] = 1'b1;
        end else begin : g_upper
            assign lz_on[gi] = |nz[DIGITS-1:gi];
        end
    end

    always_comb begin
        auto_rise     = auto_mode & ~auto_d_reg;
        dwell_wrap    = (dwell_cnt_reg == DWELL_LAST);
        sel_in_range  = ({1'b0, page_sel} < NUM_PAGES_L);

        rot_idx_next  = rot_idx_reg;
        if (auto_rise) begin
            rot_idx_next = sel_in_range ? page_sel : '0;
        end else if (auto_mode && !freeze && dwell_wrap) begin
            rot_idx_next = (rot_idx_reg == LAST_PAGE) ? '0 : rot_idx_reg + SEL_W'(1);
        end

        dwell_cnt_next = dwell_cnt_reg;
        if (!auto_mode || auto_rise) begin
            dwell_cnt_next = '0;
        end else if (!freeze) begin
            dwell_cnt_next = dwell_wrap ? '0 : dwell_cnt_reg + CNT_W'(1);
        end

        cur_page_next = cur_page_reg;
        if (!freeze) begin
            cur_page_next = auto_mode ? rot_idx_next : page_sel;
        end

        // Manual mode reads page_sel directly so the digits track it with one cycle of latency.
        disp_idx      = auto_mode ? cur_page_reg : page_sel;
        disp_in_range = ({1'b0, disp_idx} < NUM_PAGES_L);
        if (!disp_in_range) begin
            disp_val = FILL_ONES;
        end else if (show_snapshot) begin
            disp_val = snap_valid_reg ? snap_pages[disp_idx] : FILL_ONES;
        end else begin
            disp_val = live_pages[disp_idx];
        end

        hex_digits_next = freeze ? hex_digits_reg : disp_val;
        digit_on_next   = digit_on_reg;
        if (!freeze) begin
            digit_on_next = (LZ_BLANK != 0) ? lz_on : '1;
        end

        snapshot_next   = capture_stb ? page_data : snapshot_reg;
        snap_valid_next = snap_valid_reg | capture_stb;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            snapshot_reg   <= '0;
            snap_valid_reg <= 1'b0;
            dwell_cnt_reg  <= '0;
            rot_idx_reg    <= '0;
            cur_page_reg   <= '0;
            auto_d_reg     <= 1'b0;
            hex_digits_reg <= '0;
            digit_on_reg   <= '1;
        end else begin
            snapshot_reg   <= snapshot_next;
            snap_valid_reg <= snap_valid_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            rot_idx_reg    <= rot_idx_next;
            cur_page_reg   <= cur_page_next;
            auto_d_reg     <= auto_mode;
            hex_digits_reg <= hex_digits_next;
            digit_on_reg   <= digit_on_next;
        end
    end

    assign hex_digits = hex_digits_reg;
    assign digit_on   = digit_on_reg;
    assign cur_page   = cur_page_reg;
    assign snap_valid = snap_valid_reg;

endmodule

// File: tb/tb_debug_hex_pager.sv
// Directed bench for debug_hex_pager: expectations are queued with each stimulus step and
// compared against three DUT variants (plain, leading-zero blanking, six-page) after the edge.
module tb_debug_hex_pager;

    localparam int NP = 8;
    localparam int DG = 6;
    localparam int PW = DG * 4;

    typedef enum int {K_HEX_A, K_ON_A, K_PAGE_A, K_SNAP_A, K_ON_B, K_HEX_C, K_PAGE_C} kind_t;
    typedef struct {
        string tag;
        kind_t kind;
        logic [31:0] exp;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n;
    logic [PW-1:0] pages [NP];
    logic [NP*PW-1:0] page_data;
    logic [6*PW-1:0] page_data_c;
    logic [2:0] page_sel;
    logic auto_mode, freeze, capture_stb, show_snapshot;

    logic [PW-1:0] hex_a, hex_b, hex_c;
    logic [DG-1:0] on_a, on_b, on_c;
    logic [2:0] page_a, page_b, page_c;
    logic snap_a, snap_b, snap_c;

    exp_t sb [$];
    int checks = 0;
    int failures = 0;
    logic [2:0] seq [4];

    always #5 Clk = ~Clk;

    for (genvar gi = 0; gi < NP; gi++) begin : g_pack
        assign page_data[gi*PW +: PW] = pages[gi];
    end
    assign page_data_c = page_data[6*PW-1:0];

    debug_hex_pager #(.NUM_PAGES(8), .DIGITS(6), .DWELL_CYCLES(4), .LZ_BLANK(0)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .page_data(page_data), .page_sel(page_sel),
        .auto_mode(auto_mode), .freeze(freeze), .capture_stb(capture_stb),
        .show_snapshot(show_snapshot), .hex_digits(hex_a), .digit_on(on_a),
        .cur_page(page_a), .snap_valid(snap_a));

    debug_hex_pager #(.NUM_PAGES(8), .DIGITS(6), .DWELL_CYCLES(4), .LZ_BLANK(1)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .page_data(page_data), .page_sel(page_sel),
        .auto_mode(auto_mode), .freeze(freeze), .capture_stb(capture_stb),
        .show_snapshot(show_snapshot), .hex_digits(hex_b), .digit_on(on_b),
        .cur_page(page_b), .snap_valid(snap_b));

    debug_hex_pager #(.NUM_PAGES(6), .DIGITS(6), .DWELL_CYCLES(4), .LZ_BLANK(0)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .page_data(page_data_c), .page_sel(page_sel),
        .auto_mode(auto_mode), .freeze(freeze), .capture_stb(capture_stb),
        .show_snapshot(show_snapshot), .hex_digits(hex_c), .digit_on(on_c),
        .cur_page(page_c), .snap_valid(snap_c));

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_HEX_A:  return 32'(hex_a);
            K_ON_A:   return 32'(on_a);
            K_PAGE_A: return 32'(page_a);
            K_SNAP_A: return 32'(snap_a);
            K_ON_B:   return 32'(on_b);
            K_HEX_C:  return 32'(hex_c);
            K_PAGE_C: return 32'(page_c);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input kind_t k, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.kind = k;
        x.exp = e;
        sb.push_back(x);
    endtask

    // One clock edge, then drain every expectation queued for it.
    task automatic tick();
        exp_t e;
        logic [31:0] o;
        @(posedge Clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.kind);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
            if (o === e.exp) $display("check %s ok value=%h", e.tag, o);
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) pages[p] = 24'((p + 1) * 24'h100000 + p);
        seq[0] = 3'd6; seq[1] = 3'd7; seq[2] = 3'd0; seq[3] = 3'd1;
        Reset_n = 1'b0;
        page_sel = 3'd0;
        auto_mode = 1'b0;
        freeze = 1'b0;
        capture_stb = 1'b0;
        show_snapshot = 1'b0;

        tick();
        push("rst_hex", K_HEX_A, 32'h0);
        push("rst_on", K_ON_A, 32'h3F);
        push("rst_page", K_PAGE_A, 32'h0);
        push("rst_snap", K_SNAP_A, 32'h0);
        push("rst_on_b", K_ON_B, 32'h3F);
        tick();

        Reset_n = 1'b1;
        page_sel = 3'd3;
        pages[3] = 24'hABCDEF;
        push("sel3_hex", K_HEX_A, 32'hABCDEF);
        push("sel3_page", K_PAGE_A, 32'd3);
        push("sel3_on_b", K_ON_B, 32'h3F);
        tick();

        page_sel = 3'd2;
        pages[2] = 24'h0000A5;
        push("lz_a5_hex", K_HEX_A, 32'h0000A5);
        push("lz_a5_on_b", K_ON_B, 32'h03);
        push("lz_a5_on_a", K_ON_A, 32'h3F);
        tick();
        pages[2] = 24'h000000;
        push("lz_zero_hex", K_HEX_A, 32'h0);
        push("lz_zero_on_b", K_ON_B, 32'h01);
        tick();
        pages[2] = 24'h2A2A2A;

        page_sel = 3'd3;
        show_snapshot = 1'b1;
        push("placeholder_hex", K_HEX_A, 32'h111111);
        push("placeholder_snap", K_SNAP_A, 32'h0);
        tick();

        show_snapshot = 1'b0;
        pages[3] = 24'h111111;
        capture_stb = 1'b1;
        push("cap_live_hex", K_HEX_A, 32'h111111);
        tick();
        capture_stb = 1'b0;
        pages[3] = 24'h222222;
        show_snapshot = 1'b1;
        push("cap_snap_hex", K_HEX_A, 32'h111111);
        push("cap_snap_valid", K_SNAP_A, 32'h1);
        tick();
        show_snapshot = 1'b0;
        push("cap_back_live", K_HEX_A, 32'h222222);
        tick();

        page_sel = 3'd6;
        tick();
        auto_mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            push($sformatf("auto_page_%0d", k), K_PAGE_A, 32'(seq[k/4]));
            push($sformatf("auto_hex_%0d", k), K_HEX_A,
                 32'((k == 0) ? pages[6] : pages[seq[(k-1)/4]]));
            tick();
            if (k == 0) page_sel = 3'd2;
        end
        push("auto_wrap_page", K_PAGE_A, 32'd2);
        push("auto_wrap_hex", K_HEX_A, 32'(pages[1]));
        tick();
        push("pre_frz_page", K_PAGE_A, 32'd2);
        push("pre_frz_hex", K_HEX_A, 32'h2A2A2A);
        tick();

        freeze = 1'b1;
        for (int f = 0; f < 10; f++) begin
            if (f == 3) begin
                pages[2] = 24'h777777;
                capture_stb = 1'b1;
            end
            push($sformatf("frz_page_%0d", f), K_PAGE_A, 32'd2);
            push($sformatf("frz_hex_%0d", f), K_HEX_A, 32'h2A2A2A);
            tick();
            if (f == 3) begin
                capture_stb = 1'b0;
                pages[2] = 24'h2A2A2A;
            end
        end

        freeze = 1'b0;
        show_snapshot = 1'b1;
        push("rel0_page", K_PAGE_A, 32'd2);
        push("rel0_hex", K_HEX_A, 32'h777777);
        push("rel0_snap", K_SNAP_A, 32'h1);
        tick();
        push("rel1_page", K_PAGE_A, 32'd2);
        push("rel1_hex", K_HEX_A, 32'h777777);
        tick();
        push("rel2_page", K_PAGE_A, 32'd3);
        push("rel2_hex", K_HEX_A, 32'h777777);
        tick();
        push("rel3_page", K_PAGE_A, 32'd3);
        push("rel3_hex", K_HEX_A, 32'h222222);
        tick();

        Reset_n = 1'b0;
        auto_mode = 1'b0;
        show_snapshot = 1'b0;
        push("mid_rst_hex", K_HEX_A, 32'h0);
        push("mid_rst_on", K_ON_A, 32'h3F);
        push("mid_rst_page", K_PAGE_A, 32'h0);
        push("mid_rst_snap", K_SNAP_A, 32'h0);
        push("mid_rst_hex_c", K_HEX_C, 32'h0);
        tick();
        Reset_n = 1'b1;

        page_sel = 3'd7;
        push("oor_hex_c", K_HEX_C, 32'h111111);
        push("oor_page_c", K_PAGE_C, 32'd7);
        push("sel7_hex_a", K_HEX_A, 32'(pages[7]));
        tick();
        page_sel = 3'd5;
        push("sel5_hex_c", K_HEX_C, 32'(pages[5]));
        push("sel5_hex_a", K_HEX_A, 32'(pages[5]));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
